// File: rtl/write_back_pkg.sv
// Shared widths, opcode encodings, FSM states and opcode classification for write-back.
package write_back_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ADDR_W      = 10;
  localparam int unsigned OP_W        = 6;
  localparam int unsigned TO_W        = 4;
  localparam int unsigned MEM_TIMEOUT = 15;

  // Opcode encodings shared with Decode and Execution
  localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADDA  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADDCA = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUBA  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SUBCA = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ANDA  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_ANDCA = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ORA   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_ORCA  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_ASLA  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_ASRA  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ADDB  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_ADDCB = OP_W'(12);
  localparam logic [OP_W-1:0] OP_SUBB  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_SUBCB = OP_W'(14);
  localparam logic [OP_W-1:0] OP_ANDB  = OP_W'(15);
  localparam logic [OP_W-1:0] OP_ANDCB = OP_W'(16);
  localparam logic [OP_W-1:0] OP_ORB   = OP_W'(17);
  localparam logic [OP_W-1:0] OP_ORCB  = OP_W'(18);
  localparam logic [OP_W-1:0] OP_LDA   = OP_W'(19);
  localparam logic [OP_W-1:0] OP_LDB   = OP_W'(20);
  localparam logic [OP_W-1:0] OP_STA   = OP_W'(21);
  localparam logic [OP_W-1:0] OP_STB   = OP_W'(22);
  localparam logic [OP_W-1:0] OP_LDCA  = OP_W'(23);
  localparam logic [OP_W-1:0] OP_LDCB  = OP_W'(24);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } wb_state_e;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_A    = 2'd1,
    TGT_B    = 2'd2,
    TGT_MEM  = 2'd3
  } wb_target_e;

  // Which architectural resource an opcode retires into
  function automatic wb_target_e classify(input logic [OP_W-1:0] op);
    case (op)
      OP_ADDA, OP_ADDCA, OP_SUBA, OP_SUBCA, OP_ANDA, OP_ANDCA,
      OP_ORA, OP_ORCA, OP_ASLA, OP_ASRA, OP_LDCA:               return TGT_A;
      OP_ADDB, OP_ADDCB, OP_SUBB, OP_SUBCB, OP_ANDB, OP_ANDCB,
      OP_ORB, OP_ORCB, OP_LDCB:                                 return TGT_B;
      OP_LDA, OP_LDB, OP_STA, OP_STB:                           return TGT_MEM;
      default:                                                  return TGT_NONE;
    endcase
  endfunction

  // Constant loads take their value from the constant field and leave carry alone
  function automatic logic is_ldc(input logic [OP_W-1:0] op);
    return (op == OP_LDCA) || (op == OP_LDCB);
  endfunction

endpackage

// File: rtl/ffd.sv
// Generic enabled D flip-flop register with async active-high reset.
module ffd #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  // Load on enable, clear on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q_q <= '0;
    else if (en) q_q <= d;
  end

  assign q = q_q;

endmodule

// File: rtl/write_back_mem_access_fsm.sv
// Load/store sequencer: RUN/MEM_WAIT FSM, bounded ack wait and memory port registers.
module write_back_mem_access_fsm
  import write_back_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_err,
  output logic [OP_W-1:0]   mem_op,
  output logic              busy_c,
  output logic              done_c,
  output logic              load_ack_c
);

  wb_state_e         state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [OP_W-1:0]   op_q, op_d;

  // State and memory port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      op_q    <= op_d;
    end
  end

  // Next state: launch on start, exit on ack (priority) or on the last allowed wait cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    op_d       = op_q;
    done_c     = 1'b0;
    load_ack_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (start) begin
          state_d = ST_MEM_WAIT;
          req_d   = 1'b1;
          we_d    = (op_i == OP_STA) || (op_i == OP_STB);
          addr_d  = addr_i;
          wdata_d = wdata_i;
          op_d    = op_i;
          cnt_d   = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (cnt_q != '1) cnt_d = cnt_q + TO_W'(1);
        if (mem_ack) begin
          state_d    = ST_RUN;
          req_d      = 1'b0;
          done_c     = 1'b1;
          load_ack_c = !we_q;
        end else if (cnt_q >= TO_W'(MEM_TIMEOUT - 1)) begin
          state_d = ST_RUN;
          req_d   = 1'b0;
          err_d   = 1'b1;
          done_c  = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign busy_c    = (state_q == ST_MEM_WAIT);
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_err   = err_q;
  assign mem_op    = op_q;

endmodule

// File: rtl/write_back.sv
// Final pipeline stage: retires ALU results and constants into A/B, sequences loads/stores.
module write_back
  import write_back_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic [OP_W-1:0]   iOperation_EXC,
  input  logic [ADDR_W-1:0] iData_EXC,
  input  logic [DATA_W-1:0] iResult,
  input  logic              iCarry,
  input  logic              iMem_Ack,
  input  logic [DATA_W-1:0] iMem_RData,
  output logic [DATA_W-1:0] oReg_A,
  output logic              oCarryA,
  output logic [DATA_W-1:0] oReg_B,
  output logic              oCarryB,
  output logic              oMem_Req,
  output logic              oMem_We,
  output logic [ADDR_W-1:0] oMem_Addr,
  output logic [DATA_W-1:0] oMem_WData,
  output logic              oStall,
  output logic              oMem_Err,
  output logic [OP_W-1:0]   oOperation_WB
);

  wb_target_e        tgt;
  logic              busy_c, done_c, load_ack_c;
  logic [OP_W-1:0]   mem_op;
  logic [DATA_W-1:0] st_data;
  logic              a_en, ca_en, b_en, cb_en, opwb_en;
  logic [DATA_W-1:0] a_d, b_d;
  logic [OP_W-1:0]   opwb_d;

  assign tgt     = classify(iOperation_EXC);
  assign st_data = (iOperation_EXC == OP_STB) ? oReg_B : oReg_A;

  write_back_mem_access_fsm u_mem (
    .clk        (Clock),
    .rst        (Reset),
    .start      (!busy_c && (tgt == TGT_MEM)),
    .op_i       (iOperation_EXC),
    .addr_i     (iData_EXC),
    .wdata_i    (st_data),
    .mem_ack    (iMem_Ack),
    .mem_req    (oMem_Req),
    .mem_we     (oMem_We),
    .mem_addr   (oMem_Addr),
    .mem_wdata  (oMem_WData),
    .mem_err    (oMem_Err),
    .mem_op     (mem_op),
    .busy_c     (busy_c),
    .done_c     (done_c),
    .load_ack_c (load_ack_c)
  );

  assign oStall = busy_c;

  // Register write selection: ALU/constant retire in RUN, load data on MEM_WAIT exit
  always_comb begin
    a_en    = 1'b0;
    ca_en   = 1'b0;
    b_en    = 1'b0;
    cb_en   = 1'b0;
    opwb_en = 1'b0;
    a_d     = iResult;
    b_d     = iResult;
    opwb_d  = iOperation_EXC;
    if (!busy_c) begin
      opwb_en = (tgt != TGT_MEM);
      if (tgt == TGT_A) begin
        a_en = 1'b1;
        if (is_ldc(iOperation_EXC)) a_d = iData_EXC[DATA_W-1:0];
        else                        ca_en = 1'b1;
      end else if (tgt == TGT_B) begin
        b_en = 1'b1;
        if (is_ldc(iOperation_EXC)) b_d = iData_EXC[DATA_W-1:0];
        else                        cb_en = 1'b1;
      end
    end else if (done_c) begin
      opwb_en = 1'b1;
      opwb_d  = mem_op;
      if (load_ack_c) begin
        a_en = (mem_op == OP_LDA);
        b_en = (mem_op == OP_LDB);
        a_d  = iMem_RData;
        b_d  = iMem_RData;
      end
    end
  end

  ffd #(.W(DATA_W)) u_reg_a   (.clk(Clock), .rst(Reset), .en(a_en),    .d(a_d),     .q(oReg_A));
  ffd #(.W(1))      u_carry_a (.clk(Clock), .rst(Reset), .en(ca_en),   .d(iCarry),  .q(oCarryA));
  ffd #(.W(DATA_W)) u_reg_b   (.clk(Clock), .rst(Reset), .en(b_en),    .d(b_d),     .q(oReg_B));
  ffd #(.W(1))      u_carry_b (.clk(Clock), .rst(Reset), .en(cb_en),   .d(iCarry),  .q(oCarryB));
  ffd #(.W(OP_W))   u_op_wb   (.clk(Clock), .rst(Reset), .en(opwb_en), .d(opwb_d),  .q(oOperation_WB));

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: directed scenarios then randomized ops against a model.
module tb_write_back;
  import write_back_pkg::*;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic [OP_W-1:0]   iOperation_EXC = '0;
  logic [ADDR_W-1:0] iData_EXC = '0;
  logic [DATA_W-1:0] iResult = '0;
  logic              iCarry = 1'b0;
  logic              iMem_Ack = 1'b0;
  logic [DATA_W-1:0] iMem_RData = '0;
  logic [DATA_W-1:0] oReg_A, oReg_B, oMem_WData;
  logic              oCarryA, oCarryB, oMem_Req, oMem_We, oStall, oMem_Err;
  logic [ADDR_W-1:0] oMem_Addr;
  logic [OP_W-1:0]   oOperation_WB;

  int total = 0;
  int bad   = 0;

  // Architectural model
  logic [DATA_W-1:0] ra = '0, rb = '0;
  logic              rca = 1'b0, rcb = 1'b0, rerr = 1'b0;
  logic [OP_W-1:0]   ropwb = '0;

  write_back dut (
    .Clock(Clock), .Reset(Reset), .iOperation_EXC(iOperation_EXC), .iData_EXC(iData_EXC),
    .iResult(iResult), .iCarry(iCarry), .iMem_Ack(iMem_Ack), .iMem_RData(iMem_RData),
    .oReg_A(oReg_A), .oCarryA(oCarryA), .oReg_B(oReg_B), .oCarryB(oCarryB),
    .oMem_Req(oMem_Req), .oMem_We(oMem_We), .oMem_Addr(oMem_Addr), .oMem_WData(oMem_WData),
    .oStall(oStall), .oMem_Err(oMem_Err), .oOperation_WB(oOperation_WB)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_reg_a"},  32'(oReg_A),        32'(ra));
    check({tag, "_carry_a"},32'(oCarryA),       32'(rca));
    check({tag, "_reg_b"},  32'(oReg_B),        32'(rb));
    check({tag, "_carry_b"},32'(oCarryB),       32'(rcb));
    check({tag, "_err"},    32'(oMem_Err),      32'(rerr));
    check({tag, "_op_wb"},  32'(oOperation_WB), 32'(ropwb));
  endtask

  function automatic bit alu_to_a(input logic [OP_W-1:0] op);
    return op inside {OP_ADDA, OP_ADDCA, OP_SUBA, OP_SUBCA, OP_ANDA, OP_ANDCA,
                      OP_ORA, OP_ORCA, OP_ASLA, OP_ASRA};
  endfunction

  function automatic bit alu_to_b(input logic [OP_W-1:0] op);
    return op inside {OP_ADDB, OP_ADDCB, OP_SUBB, OP_SUBCB, OP_ANDB, OP_ANDCB, OP_ORB, OP_ORCB};
  endfunction

  // One non-memory op retired in RUN; a stray ack must be ignored
  task automatic alu_op(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] res,
                        input logic c, input logic [ADDR_W-1:0] d);
    iOperation_EXC = op; iResult = res; iCarry = c; iData_EXC = d;
    iMem_Ack = 1'($urandom_range(0, 1)); iMem_RData = DATA_W'($urandom);
    @(negedge Clock);
    if (alu_to_a(op))      begin ra = res; rca = c; end
    else if (alu_to_b(op)) begin rb = res; rcb = c; end
    else if (op == OP_LDCA) ra = d[DATA_W-1:0];
    else if (op == OP_LDCB) rb = d[DATA_W-1:0];
    ropwb = op;
    iMem_Ack = 1'b0;
    check("alu_stall", 32'(oStall), 32'd0);
    check("alu_req",   32'(oMem_Req), 32'd0);
    check_regs("alu");
  endtask

  // Memory op; ack_at is the wait cycle carrying the ack (0 or >15: never)
  task automatic mem_op(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] addr,
                        input int ack_at, input logic [DATA_W-1:0] rdata);
    logic             store;
    logic [DATA_W-1:0] sdata;
    bit               done;
    store = (op == OP_STA) || (op == OP_STB);
    sdata = (op == OP_STA) ? ra : rb;
    iOperation_EXC = op; iData_EXC = addr; iMem_Ack = 1'b0;
    @(negedge Clock);
    check("mem_req",  32'(oMem_Req),  32'd1);
    check("mem_we",   32'(oMem_We),   32'(store));
    check("mem_addr", 32'(oMem_Addr), 32'(addr));
    if (store) check("mem_wdata", 32'(oMem_WData), 32'(sdata));
    done = 0;
    for (int k = 1; k <= 20 && !done; k++) begin
      iMem_Ack = (k == ack_at);
      iMem_RData = rdata;
      iResult = DATA_W'($urandom); iCarry = 1'($urandom_range(0, 1));
      check("wait_stall", 32'(oStall),   32'd1);
      check("wait_req",   32'(oMem_Req), 32'd1);
      @(negedge Clock);
      if (k == ack_at) begin
        if (op == OP_LDA) ra = rdata;
        if (op == OP_LDB) rb = rdata;
        done = 1;
      end else if (k == MEM_TIMEOUT) begin
        rerr = 1'b1;
        done = 1;
      end
      if (done) ropwb = op;
    end
    iMem_Ack = 1'b0;
    check("exit_req",   32'(oMem_Req), 32'd0);
    check("exit_stall", 32'(oStall),   32'd0);
    check_regs("mem");
  endtask

  initial begin
    logic [OP_W-1:0] op;
    // Reset state
    #1;
    check("rst_req",   32'(oMem_Req), 32'd0);
    check("rst_stall", 32'(oStall),   32'd0);
    check_regs("rst");
    @(negedge Clock); @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check_regs("post_rst");

    // Directed scenarios
    alu_op(OP_ADDA, 8'hF0, 1'b1, '0);
    alu_op(OP_ORCB, 8'h5A, 1'b0, '0);
    alu_op(OP_ASRA, 8'h0F, 1'b0, '0);
    alu_op(OP_ADDB, 8'h33, 1'b1, '0);
    alu_op(OP_NOP,  8'hEE, 1'b0, 10'h0AB);
    alu_op(OP_W'(40), 8'hDD, 1'b1, 10'h0CD);
    alu_op(OP_LDCA, 8'h99, 1'b0, 10'h311);
    mem_op(OP_LDB, 10'h123, 3, 8'hC3);
    alu_op(OP_LDCA, 8'h00, 1'b1, 10'h07E);
    mem_op(OP_STA, 10'h3FF, 2, 8'h44);
    alu_op(OP_LDCB, 8'h00, 1'b0, 10'h2B6);
    mem_op(OP_STB, 10'h001, 1, 8'h55);
    mem_op(OP_LDA, 10'h055, MEM_TIMEOUT, 8'hA5);
    mem_op(OP_LDA, 10'h2AA, 0, 8'h12);

    // Reset while waiting on memory: outputs clear before the next edge
    iOperation_EXC = OP_LDB; iData_EXC = 10'h100;
    @(negedge Clock); @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    ra = '0; rb = '0; rca = 1'b0; rcb = 1'b0; rerr = 1'b0; ropwb = '0;
    check("midrst_req",   32'(oMem_Req), 32'd0);
    check("midrst_stall", 32'(oStall),   32'd0);
    check_regs("midrst");
    iOperation_EXC = OP_NOP;
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check_regs("after_midrst");

    // Randomized mix
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        op = OP_LDA + OP_W'($urandom_range(0, 3));
        mem_op(op, ADDR_W'($urandom), $urandom_range(1, 17), DATA_W'($urandom));
      end else begin
        op = OP_W'($urandom_range(0, 63));
        if (op inside {OP_LDA, OP_LDB, OP_STA, OP_STB}) op = OP_NOP;
        alu_op(op, DATA_W'($urandom), 1'($urandom_range(0, 1)), ADDR_W'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
